// File: rtl/fetch_sequencer_if.sv
// IF-stage control bundle: pipeline events into the fetch sequencer, PC/IF-ID controls out.
// master = fetch_sequencer side, slave = pipeline / stimulus side.
interface fetch_sequencer_if;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic       jump_req;
   logic [7:0] jump_target;
   logic       hazard_stall;
   logic [3:0] opcode;
   logic       resume;

   logic       pc_select;
   logic       select_line;
   logic [7:0] new_address;
   logic       if_id_flush;
   logic       if_id_hold;
   logic [1:0] fsm_state;

   modport master (
      input  branch_taken, branch_target, jump_req, jump_target,
             hazard_stall, opcode, resume,
      output pc_select, select_line, new_address, if_id_flush,
             if_id_hold, fsm_state
   );

   modport slave (
      output branch_taken, branch_target, jump_req, jump_target,
             hazard_stall, opcode, resume,
      input  pc_select, select_line, new_address, if_id_flush,
             if_id_hold, fsm_state
   );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage control FSM (RUN/STALL/FLUSH/HALTED); Mealy outputs, redirect loads PC on the next edge.
// Optional perf counters under FETCH_PERF_CNT_EN; outputs forced to 0 while reset is low.
module fetch_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [3:0]  HALT_OPCODE  = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cycles,
   output logic [15:0]        flush_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   logic       pc_select_c;
   logic       select_line_c;
   logic [7:0] new_address_c;
   logic       if_id_flush_c;
   logic       if_id_hold_c;
   logic       redirect;

   assign redirect = bus.branch_taken | bus.jump_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_select_c   = 1'b0;
      select_line_c = 1'b0;
      new_address_c = 8'h00;
      if_id_flush_c = 1'b0;
      if_id_hold_c  = 1'b0;

      case (state_q)
         ST_RUN, ST_STALL: begin
            if (redirect) begin
               pc_select_c   = 1'b1;
               select_line_c = 1'b1;
               if_id_flush_c = 1'b1;
               new_address_c = bus.branch_taken ? bus.branch_target : bus.jump_target;
               cnt_d         = FLUSH_LOAD;
               state_d       = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
            end else if (bus.hazard_stall) begin
               if_id_hold_c = 1'b1;
               state_d      = ST_STALL;
            end else if (bus.opcode == HALT_OPCODE) begin
               // HALT still outranks nothing but plain fetch, in STALL as well as RUN
               if_id_hold_c = 1'b1;
               state_d      = ST_HALTED;
            end else begin
               pc_select_c = 1'b1;
               state_d     = ST_RUN;
            end
         end

         ST_FLUSH: begin
            // Instructions arriving here are squashed, so every event input is ignored
            pc_select_c   = 1'b1;
            if_id_flush_c = 1'b1;
            if (cnt_q == 3'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         ST_HALTED: begin
            if_id_hold_c = 1'b1;
            if (bus.resume) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Reset gates the Mealy outputs so the pipeline sees all-zero controls immediately
   assign bus.pc_select   = reset & pc_select_c;
   assign bus.select_line = reset & select_line_c;
   assign bus.new_address = reset ? new_address_c : 8'h00;
   assign bus.if_id_flush = reset & if_id_flush_c;
   assign bus.if_id_hold  = reset & if_id_hold_c;
   assign bus.fsm_state   = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (((state_q == ST_STALL) || (state_q == ST_HALTED)) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (if_id_flush_c && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`endif

endmodule
